// File: rtl/ex_regdecr_reg_decr_pipe.sv
// Elastic nstages-deep registered decrementer with valid/ready handshakes on both ends.
// Define EX_REGDECR_REG_DECR_PIPE_SATURATE_EN to clamp each stage at zero instead of wrapping.
module ex_regdecr_reg_decr_pipe #(
    parameter int nbits   = 8,
    parameter int nstages = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_val,
    output logic                         in_rdy,
    input  logic [nbits-1:0]             in_msg,
    output logic                         out_val,
    input  logic                         out_rdy,
    output logic [nbits-1:0]             out_msg,
    output logic [$clog2(nstages+1)-1:0] occupancy
);
    localparam int               OCC_W = $clog2(nstages + 1);
    localparam logic [nbits-1:0] ONE   = nbits'(1);

    function automatic logic [nbits-1:0] f_decr(input logic [nbits-1:0] x);
`ifdef EX_REGDECR_REG_DECR_PIPE_SATURATE_EN
        return (x == '0) ? '0 : x - ONE;
`else
        return x - ONE;
`endif
    endfunction

    logic [nstages-1:0] r_val;
    logic [nbits-1:0]   r_data    [nstages];
    logic [nstages-1:0] w_rdy;
    logic [nstages-1:0] w_up_val;
    logic [nbits-1:0]   w_up_data [nstages];
    logic [OCC_W-1:0]   w_occ;

    // A stage is ready if it, or any stage downstream of it, has room this cycle.
    always_comb begin
        logic l_chain;
        l_chain = out_rdy;
        w_rdy   = '0;
        for (int k = nstages - 1; k >= 0; k--) begin
            l_chain  = l_chain || !r_val[k];
            w_rdy[k] = l_chain;
        end
    end

    always_comb begin
        w_up_val     = '0;
        w_up_val[0]  = in_val;
        w_up_data[0] = in_msg;
        for (int k = 1; k < nstages; k++) begin
            w_up_val[k]  = r_val[k-1];
            w_up_data[k] = r_data[k-1];
        end
    end

    always_comb begin
        w_occ = '0;
        for (int k = 0; k < nstages; k++) begin
            w_occ = w_occ + OCC_W'(r_val[k]);
        end
    end

    // NOTE: data registers are reset too, so out_msg reads 0 out of reset rather than X.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_val <= '0;
            for (int k = 0; k < nstages; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < nstages; k++) begin
                if (w_rdy[k]) begin
                    r_val[k] <= w_up_val[k];
                    if (w_up_val[k]) begin
                        r_data[k] <= f_decr(w_up_data[k]);
                    end
                end
            end
        end
    end

    assign in_rdy    = w_rdy[0];
    assign out_val   = r_val[nstages-1];
    assign out_msg   = r_data[nstages-1];
    assign occupancy = w_occ;

endmodule
